// File: rtl/i2c_cmd_sequencer_if.sv
// Bus bundle for i2c_cmd_sequencer: command push side, I2C_top_module drive/return side,
// and response strobe. "slave" is the sequencer's view, "master" the surrounding logic.
interface i2c_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data1;
   logic [7:0] cmd_data2;

   logic       i2c_send;
   logic       i2c_r_w;
   logic [6:0] i2c_address;
   logic [7:0] i2c_data_in_1;
   logic [7:0] i2c_data_in_2;
   logic       i2c_tx_done;
   logic       i2c_rx_done;
   logic [7:0] i2c_rd_data;

   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_data1, cmd_data2,
      input  cmd_ready,
      input  i2c_send, i2c_r_w, i2c_address, i2c_data_in_1, i2c_data_in_2,
      output i2c_tx_done, i2c_rx_done, i2c_rd_data,
      input  rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_data1, cmd_data2,
      output cmd_ready,
      output i2c_send, i2c_r_w, i2c_address, i2c_data_in_1, i2c_data_in_2,
      input  i2c_tx_done, i2c_rx_done, i2c_rd_data,
      output rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO + replay FSM in front of I2C_top_module; one response per command.
// Optional WAIT-state timeout is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SEND_HOLD   = 10,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                            clk,
   input  logic                            rst,
   i2c_cmd_sequencer_if.slave              bus,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(SEND_HOLD + 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SEND_HOLD < 1 || TIMEOUT_CYC < 1)
   begin : g_param_check
      $error("i2c_cmd_sequencer: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESP} state_t;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] d1;
      logic [7:0] d2;
   } cmd_t;

   state_t        state_reg, state_next;
   cmd_t          mem [FIFO_DEPTH];
   cmd_t          head_reg;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [HW-1:0] hold_cnt_reg;
   logic          tx_prev_reg, rx_prev_reg;
   logic          sticky_reg;
   logic [7:0]    rd_cap_reg;
   logic          push, pop;
   logic          tx_edge, rx_edge, match;
   logic          timeout_hit, err_flag;
   logic          send_c, rsp_valid_c;

   assign bus.cmd_ready = (count_reg < CW'(FIFO_DEPTH));
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign pop           = (state_reg == IDLE) && (count_reg != '0);

   assign tx_edge = bus.i2c_tx_done && !tx_prev_reg;
   assign rx_edge = bus.i2c_rx_done && !rx_prev_reg;
   // Only the edge that matches the command direction counts as completion.
   assign match   = head_reg.rw ? rx_edge : tx_edge;

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wait_cnt_reg;
   logic          err_reg;

   assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == TW'(TIMEOUT_CYC - 1));
   assign err_flag    = err_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else if (state_reg == LOAD) begin
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else if (state_reg == WAIT) begin
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
         if (timeout_hit && !sticky_reg && !match)
            err_reg <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err_flag    = 1'b0;
`endif

   // Storage array carries no reset so it maps onto RAM; head is read registered on pop.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= '{rw: bus.cmd_rw, addr: bus.cmd_addr, d1: bus.cmd_data1, d2: bus.cmd_data2};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            head_reg   <= mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_prev_reg  <= 1'b0;
         rx_prev_reg  <= 1'b0;
         sticky_reg   <= 1'b0;
         hold_cnt_reg <= '0;
         rd_cap_reg   <= 8'h00;
      end else begin
         tx_prev_reg <= bus.i2c_tx_done;
         rx_prev_reg <= bus.i2c_rx_done;
         if (state_reg == LOAD) begin
            sticky_reg   <= 1'b0;
            hold_cnt_reg <= '0;
            rd_cap_reg   <= 8'h00;
         end
         if (state_reg == SEND) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
            if (match)
               sticky_reg <= 1'b1;
         end
         // Keep the byte from the first completing rx_done edge.
         if ((state_reg == SEND || state_reg == WAIT) && head_reg.rw && rx_edge && !sticky_reg)
            rd_cap_reg <= bus.i2c_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      send_c      = 1'b0;
      rsp_valid_c = 1'b0;
      case (state_reg)
         IDLE: if (pop) state_next = LOAD;
         LOAD: state_next = SEND;
         SEND: begin
            send_c = 1'b1;
            if (hold_cnt_reg == HW'(SEND_HOLD - 1))
               state_next = WAIT;
         end
         WAIT: if (sticky_reg || match || timeout_hit) state_next = RESP;
         RESP: begin
            rsp_valid_c = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.i2c_send      = send_c;
   assign bus.i2c_r_w       = head_reg.rw;
   assign bus.i2c_address   = head_reg.addr;
   assign bus.i2c_data_in_1 = head_reg.d1;
   assign bus.i2c_data_in_2 = head_reg.d2;

   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_data  = (rsp_valid_c && head_reg.rw && !err_flag) ? rd_cap_reg : 8'h00;
   assign bus.rsp_err   = rsp_valid_c && err_flag;

   assign busy       = (state_reg != IDLE);
   assign fifo_count = count_reg;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer; the timeout scenario runs only when
// I2C_SEQ_TIMEOUT_EN is defined for both bench and design.
module tb_i2c_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       busy;
   logic [2:0] fifo_count;
   int         vectors = 0;
   int         miscompares = 0;

   i2c_cmd_sequencer_if bus ();

   i2c_cmd_sequencer #(.FIFO_DEPTH(4), .SEND_HOLD(10), .TIMEOUT_CYC(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rw, input logic [6:0] addr, input logic [7:0] d1, input logic [7:0] d2);
      bus.cmd_rw    = rw;
      bus.cmd_addr  = addr;
      bus.cmd_data1 = d1;
      bus.cmd_data2 = d2;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_send(input logic level, input string tag);
      int n = 0;
      while (bus.i2c_send !== level && n < 60) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.i2c_send !== level) begin
         miscompares++;
         $display("FAIL %s: i2c_send=%b required %b", tag, bus.i2c_send, level);
      end
   endtask

   task automatic finish_cmd(input logic rw, input logic [7:0] rdata, input string tag);
      int n = 0;
      logic [7:0] exp_data;
      exp_data = rw ? rdata : 8'h00;
      if (rw) begin
         bus.i2c_rd_data = rdata;
         bus.i2c_rx_done = 1'b1;
      end else begin
         bus.i2c_tx_done = 1'b1;
      end
      tick();
      bus.i2c_rx_done = 1'b0;
      bus.i2c_tx_done = 1'b0;
      while (bus.rsp_valid !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.rsp_valid !== 1'b1 || n != 0) begin
         miscompares++;
         $display("FAIL %s_rsp_valid: rsp_valid=%b after %0d extra cycles, required 1 at once", tag, bus.rsp_valid, n);
      end
      vectors++;
      if (bus.rsp_data !== exp_data || bus.rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_rsp: data=%h err=%b required data=%h err=0", tag, bus.rsp_data, bus.rsp_err, exp_data);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_rsp_strobe: rsp_valid=%b required 0 one cycle later", tag, bus.rsp_valid);
      end
   endtask

   task automatic serve(input logic rw, input logic [6:0] addr, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] rdata, input string tag, output int gap);
      int n = 0;
      int hc = 0;
      while (bus.i2c_send !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      gap = n;
      vectors++;
      if (bus.i2c_send !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_send_start: i2c_send=%b required 1", tag, bus.i2c_send);
      end
      vectors++;
      if ({bus.i2c_r_w, bus.i2c_address, bus.i2c_data_in_1, bus.i2c_data_in_2} !== {rw, addr, d1, d2}) begin
         miscompares++;
         $display("FAIL %s_fields: rw=%b addr=%h d1=%h d2=%h required rw=%b addr=%h d1=%h d2=%h", tag,
                  bus.i2c_r_w, bus.i2c_address, bus.i2c_data_in_1, bus.i2c_data_in_2, rw, addr, d1, d2);
      end
      while (bus.i2c_send === 1'b1 && hc < 60) begin
         tick();
         hc++;
      end
      vectors++;
      if (hc != 10) begin
         miscompares++;
         $display("FAIL %s_send_hold: i2c_send high %0d cycles required 10", tag, hc);
      end
      finish_cmd(rw, rdata, tag);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      vectors++;
      if (bus.cmd_ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: cmd_ready=%b fifo_count=%0d busy=%b required 1 0 0", bus.cmd_ready, fifo_count, busy);
      end
      vectors++;
      if ({bus.i2c_send, bus.i2c_r_w, bus.i2c_address, bus.i2c_data_in_1, bus.i2c_data_in_2} !== 25'd0 ||
          {bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: send=%b addr=%h rsp_valid=%b rsp_data=%h required all 0",
                  bus.i2c_send, bus.i2c_address, bus.rsp_valid, bus.rsp_data);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      int gap;
      push(1'b0, 7'h2D, 8'hB7, 8'h56);
      vectors++;
      if (fifo_count !== 3'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL write_accept: fifo_count=%0d busy=%b required 1 0", fifo_count, busy);
      end
      tick();
      vectors++;
      if (busy !== 1'b1 || bus.i2c_send !== 1'b0 || fifo_count !== 3'd0) begin
         miscompares++;
         $display("FAIL write_load: busy=%b send=%b fifo_count=%0d required 1 0 0", busy, bus.i2c_send, fifo_count);
      end
      tick();
      vectors++;
      if (bus.i2c_send !== 1'b1) begin
         miscompares++;
         $display("FAIL write_latency: i2c_send=%b required 1 three cycles after accept", bus.i2c_send);
      end
      serve(1'b0, 7'h2D, 8'hB7, 8'h56, 8'h00, "write", gap);
   endtask

   task automatic test_read();
      int gap;
      push(1'b1, 7'h2D, 8'h00, 8'h00);
      serve(1'b1, 7'h2D, 8'h00, 8'h00, 8'hA5, "read", gap);
   endtask

   task automatic test_fill();
      int gap;
      int sends = 0;
      logic [6:0] a;
      push(1'b1, 7'h10, 8'h01, 8'h02);
      wait_send(1'b1, "fill_first_send");
      wait_send(1'b0, "fill_first_wait");
      for (int i = 0; i < 4; i++) begin
         bus.cmd_rw    = 1'b1;
         bus.cmd_addr  = 7'h11 + 7'(i);
         bus.cmd_data1 = 8'(i);
         bus.cmd_data2 = 8'h80 + 8'(i);
         bus.cmd_valid = 1'b1;
         tick();
      end
      vectors++;
      if (bus.cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
         miscompares++;
         $display("FAIL fill_full: cmd_ready=%b fifo_count=%0d required 0 4", bus.cmd_ready, fifo_count);
      end
      bus.cmd_addr = 7'h15;
      tick();
      bus.cmd_valid = 1'b0;
      vectors++;
      if (fifo_count !== 3'd4 || bus.i2c_address !== 7'h10) begin
         miscompares++;
         $display("FAIL fill_drop: fifo_count=%0d addr=%h required 4 10", fifo_count, bus.i2c_address);
      end
      finish_cmd(1'b1, 8'h90, "fill_head");
      for (int i = 0; i < 4; i++) begin
         a = 7'h11 + 7'(i);
         serve(1'b1, a, 8'(i), 8'h80 + 8'(i), 8'hC0 + 8'(i), "fill_order", gap);
         vectors++;
         if (gap != 2) begin
            miscompares++;
            $display("FAIL fill_gap: send rose %0d cycles after strobe cleared, required 2", gap);
         end
      end
      for (int i = 0; i < 20; i++) begin
         if (bus.i2c_send === 1'b1) sends++;
         tick();
      end
      vectors++;
      if (sends != 0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_fifth: send cycles=%0d fifo_count=%0d busy=%b required 0 0 0", sends, fifo_count, busy);
      end
   endtask

   task automatic test_early_done();
      int hc = 0;
      int seen = 0;
      push(1'b0, 7'h33, 8'h44, 8'h55);
      wait_send(1'b1, "early_send");
      tick();
      bus.i2c_rx_done = 1'b1;
      tick();
      bus.i2c_rx_done = 1'b0;
      tick();
      tick();
      bus.i2c_tx_done = 1'b1;
      tick();
      bus.i2c_tx_done = 1'b0;
      while (bus.i2c_send === 1'b1 && hc < 30) begin
         tick();
         hc++;
      end
      vectors++;
      if (hc != 5 || bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL early_hold: remaining send cycles=%0d rsp_valid=%b required 5 0", hc, bus.rsp_valid);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00) begin
         miscompares++;
         $display("FAIL early_rsp: rsp_valid=%b rsp_data=%h required 1 00 on first cycle after WAIT", bus.rsp_valid, bus.rsp_data);
      end
      tick();
      push(1'b1, 7'h22, 8'h00, 8'h00);
      wait_send(1'b1, "wrong_send");
      wait_send(1'b0, "wrong_wait");
      bus.i2c_tx_done = 1'b1;
      tick();
      bus.i2c_tx_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_valid === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL wrong_edge: rsp_valid seen %0d times after tx_done on read, required 0", seen);
      end
      finish_cmd(1'b1, 8'h3C, "wrong_edge_read");
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      push(1'b0, 7'h40, 8'h01, 8'h01);
      wait_send(1'b1, "rstmid_send");
      wait_send(1'b0, "rstmid_wait");
      push(1'b0, 7'h41, 8'h02, 8'h02);
      push(1'b0, 7'h42, 8'h03, 8'h03);
      vectors++;
      if (fifo_count !== 3'd2 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_queue: fifo_count=%0d busy=%b required 2 1", fifo_count, busy);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.i2c_send !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0 || bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_clear: send=%b busy=%b fifo_count=%0d rsp_valid=%b required 0 0 0 0",
                  bus.i2c_send, busy, fifo_count, bus.rsp_valid);
      end
      rst = 1'b1;
      bus.i2c_tx_done = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (bus.rsp_valid === 1'b1 || bus.i2c_send === 1'b1) seen++;
         tick();
      end
      bus.i2c_tx_done = 1'b0;
      tick();
      vectors++;
      if (seen != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_quiet: activity cycles=%0d busy=%b required 0 0", seen, busy);
      end
   endtask

`ifdef I2C_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int k = 0;
      int gap;
      push(1'b1, 7'h50, 8'h00, 8'h00);
      push(1'b0, 7'h51, 8'h61, 8'h62);
      wait_send(1'b1, "tmo_send");
      wait_send(1'b0, "tmo_wait");
      while (bus.rsp_valid !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      vectors++;
      if (k != 16) begin
         miscompares++;
         $display("FAIL tmo_cycles: response after %0d WAIT cycles required 16", k);
      end
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00) begin
         miscompares++;
         $display("FAIL tmo_rsp: valid=%b err=%b data=%h required 1 1 00", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      tick();
      serve(1'b0, 7'h51, 8'h61, 8'h62, 8'h00, "tmo_next", gap);
   endtask
`endif

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_rw      = 1'b0;
      bus.cmd_addr    = 7'h00;
      bus.cmd_data1   = 8'h00;
      bus.cmd_data2   = 8'h00;
      bus.i2c_tx_done = 1'b0;
      bus.i2c_rx_done = 1'b0;
      bus.i2c_rd_data = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_early_done();
      test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
